// File: rtl/uart_event_reporter.sv
// Game event reporter: queues {code, score} snapshots and streams each one to the
// shared uart core as an 8-byte ASCII line such as "P 1A2F\r\n".
module uart_event_reporter #(
   parameter int DEPTH      = 8,
   parameter int HS_TIMEOUT = 15
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    evt_valid,
   input  logic [2:0]              evt_code,
   input  logic [15:0]             score,
   input  logic                    enable,
   output logic                    transmit,
   output logic [7:0]              tx_byte,
   input  logic                    is_transmitting,
   output logic                    busy,
   output logic [$clog2(DEPTH):0]  fifo_level,
   output logic [7:0]              dropped
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(HS_TIMEOUT + 1);
   localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
   localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
   localparam logic [LW-1:0] LEVEL_ZERO = LW'(0);
   localparam logic [AW-1:0] PTR_ONE    = AW'(1);
   localparam logic [CW-1:0] LAST_WAIT  = CW'(HS_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_SEND      = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } state_t;

   state_t          state_r, state_s;
   logic [18:0]     mem_r [DEPTH];
   logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
   logic [LW-1:0]   level_r;
   logic [7:0]      dropped_r;
   logic [18:0]     line_r;
   logic [2:0]      idx_r;
   logic [CW-1:0]   cnt_r;
   logic            transmit_r;
   logic [7:0]      tx_byte_r;
   logic            full_s, push_s, pop_s, fire_s, timeout_s, advance_s, busy_s;

   function automatic logic [7:0] hex_char(input logic [3:0] nib);
      logic [7:0] c;
      if (nib < 4'd10) c = 8'h30 + {4'h0, nib};
      else             c = 8'h37 + {4'h0, nib};
      return c;
   endfunction

   function automatic logic [7:0] code_char(input logic [2:0] code);
      logic [7:0] c;
      case (code)
         3'd0:    c = 8'h4C;
         3'd1:    c = 8'h52;
         3'd2:    c = 8'h44;
         3'd3:    c = 8'h50;
         3'd4:    c = 8'h48;
         3'd5:    c = 8'h58;
         3'd6:    c = 8'h5A;
         3'd7:    c = 8'h42;
         default: c = 8'h3F;
      endcase
      return c;
   endfunction

   function automatic logic [7:0] line_char(input logic [18:0] line, input logic [2:0] idx);
      logic [7:0] c;
      case (idx)
         3'd0:    c = code_char(line[18:16]);
         3'd1:    c = 8'h20;
         3'd2:    c = hex_char(line[15:12]);
         3'd3:    c = hex_char(line[11:8]);
         3'd4:    c = hex_char(line[7:4]);
         3'd5:    c = hex_char(line[3:0]);
         3'd6:    c = 8'h0D;
         3'd7:    c = 8'h0A;
         default: c = 8'h00;
      endcase
      return c;
   endfunction

   // Per-state control strobes; a full FIFO blocks pushes even when a pop happens this cycle.
   always_comb begin
      full_s    = (level_r == FULL_LEVEL);
      push_s    = evt_valid & ~full_s;
      pop_s     = 1'b0;
      fire_s    = 1'b0;
      timeout_s = 1'b0;
      advance_s = 1'b0;
      busy_s    = 1'b1;
      case (state_r)
         ST_IDLE: begin
            busy_s = 1'b0;
            pop_s  = enable & (level_r != LEVEL_ZERO);
         end
         ST_SEND:      fire_s    = ~is_transmitting;
         ST_WAIT_BUSY: timeout_s = ~is_transmitting & (cnt_r == LAST_WAIT);
         ST_WAIT_DONE: advance_s = ~is_transmitting;
         default:      busy_s    = 1'b0;
      endcase
   end

   // Next-state decode of the line sequencer.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (pop_s) state_s = ST_SEND;
            else       state_s = ST_IDLE;
         end
         ST_SEND: begin
            if (fire_s) state_s = ST_WAIT_BUSY;
            else        state_s = ST_SEND;
         end
         ST_WAIT_BUSY: begin
            if (is_transmitting) state_s = ST_WAIT_DONE;
            else if (timeout_s)  state_s = ST_SEND;
            else                 state_s = ST_WAIT_BUSY;
         end
         ST_WAIT_DONE: begin
            if (advance_s) begin
               if (idx_r == 3'd7) state_s = ST_IDLE;
               else               state_s = ST_SEND;
            end else begin
               state_s = ST_WAIT_DONE;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // Sequencer state, line buffer, byte index, handshake timer and registered uart strobes.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r    <= ST_IDLE;
         line_r     <= 19'h00000;
         idx_r      <= 3'd0;
         cnt_r      <= '0;
         transmit_r <= 1'b0;
         tx_byte_r  <= 8'h00;
      end else begin
         state_r    <= state_s;
         transmit_r <= fire_s;
         if (fire_s) tx_byte_r <= line_char(line_r, idx_r);
         if (pop_s) begin
            line_r <= mem_r[rd_ptr_r];
            idx_r  <= 3'd0;
         end else if (advance_s && idx_r != 3'd7) begin
            idx_r  <= idx_r + 3'd1;
         end
         // Retry timer counts WAIT_BUSY cycles since the last pulse.
         if (fire_s)                       cnt_r <= '0;
         else if (state_r == ST_WAIT_BUSY) cnt_r <= cnt_r + CW'(1);
      end
   end

   // FIFO pointers, occupancy and the saturating overflow counter.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_r  <= '0;
         rd_ptr_r  <= '0;
         level_r   <= LEVEL_ZERO;
         dropped_r <= 8'h00;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
         case ({push_s, pop_s})
            2'b10:   level_r <= level_r + LEVEL_ONE;
            2'b01:   level_r <= level_r - LEVEL_ONE;
            default: level_r <= level_r;
         endcase
         if (evt_valid && full_s && dropped_r != 8'hFF) dropped_r <= dropped_r + 8'd1;
      end
   end

   // FIFO storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push_s) mem_r[wr_ptr_r] <= {evt_code, score};
   end

   assign transmit   = transmit_r;
   assign tx_byte    = tx_byte_r;
   assign busy       = busy_s;
   assign fifo_level = level_r;
   assign dropped    = dropped_r;

endmodule
